// File: rtl/dualport_ram_ctl_if.sv
// Bus bundle for the two-port RAM controller: port A/B requests, read data,
// valid strobes, collision strobe and the ready flag.
interface dualport_ram_ctl_if #(
    parameter int DATA_W = 7,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic              en_a, en_b;
    logic              rw_a, rw_b;
    logic [ADDR_W-1:0] address_a, address_b;
    logic [DATA_W-1:0] data_in_a, data_in_b;
    logic [DATA_W-1:0] data_out_a, data_out_b;
    logic              valid_a, valid_b;
    logic              collision;

    modport master (
        input  ready, data_out_a, data_out_b, valid_a, valid_b, collision,
        output en_a, en_b, rw_a, rw_b, address_a, address_b, data_in_a, data_in_b
    );

    modport slave (
        output ready, data_out_a, data_out_b, valid_a, valid_b, collision,
        input  en_a, en_b, rw_a, rw_b, address_a, address_b, data_in_a, data_in_b
    );
endinterface

// File: rtl/dualport_ram_ctl.sv
// Two-port single-clock RAM with post-reset clear sequencer, read-valid strobes
// and port-A-wins write collision arbitration.
module dualport_ram_ctl #(
    parameter int                DATA_W    = 7,
    parameter int                ADDR_W    = 5,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input logic              clk,
    input logic              reset,
    dualport_ram_ctl_if.slave bus
);
    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    // Index 0 is port A, index 1 is port B
    logic [1:0]             en, rw, we, rd, vld;
    logic [1:0][ADDR_W-1:0] addr;
    logic [1:0][DATA_W-1:0] din, dout;
    logic                   run, clr_we, clash, coll_q;

    assign en   = {bus.en_b, bus.en_a};
    assign rw   = {bus.rw_b, bus.rw_a};
    assign addr = {bus.address_b, bus.address_a};
    assign din  = {bus.data_in_b, bus.data_in_a};

    assign bus.ready      = run;
    assign bus.data_out_a = dout[0];
    assign bus.data_out_b = dout[1];
    assign bus.valid_a    = vld[0];
    assign bus.valid_b    = vld[1];
    assign bus.collision  = coll_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == LAST) state_nxt = RUN;
    end

    always_comb begin
        run    = (state == RUN);
        clr_we = (state == CLEAR);
        we     = '0;
        rd     = '0;
        for (int p = 0; p < 2; p++) begin
            we[p] = run & en[p] & rw[p];
            rd[p] = run & en[p] & ~rw[p];
        end
        // Same-address double write: A's data is kept, B's write is squashed
        clash = we[0] & we[1] & (addr[0] == addr[1]);
        we[1] = we[1] & ~clash;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt[ADDR_W-1:0]] <= CLEAR_VAL;
        end else begin
            for (int p = 0; p < 2; p++)
                if (we[p]) mem[addr[p]] <= din[p];
        end
    end

    // Reads sample the array before this edge's writes land: read-before-write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout   <= '0;
            vld    <= '0;
            coll_q <= 1'b0;
        end else begin
            vld    <= rd;
            coll_q <= clash;
            for (int p = 0; p < 2; p++)
                if (rd[p]) dout[p] <= mem[addr[p]];
        end
    end
endmodule

// File: tb/tb_dualport_ram_ctl.sv
// Directed self-checking bench for dualport_ram_ctl: default 32x7 instance and
// an 8x12 instance with a non-zero clear value.
module tb_dualport_ram_ctl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst3 = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dualport_ram_ctl_if #(.DATA_W(7), .ADDR_W(5)) b ();
    dualport_ram_ctl_if #(.DATA_W(12), .ADDR_W(3)) b3 ();

    dualport_ram_ctl dut (.clk(clk), .reset(reset), .bus(b));
    dualport_ram_ctl #(.DATA_W(12), .ADDR_W(3), .CLEAR_VAL(12'hABC)) dut3 (
        .clk(clk), .reset(rst3), .bus(b3));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.en_a = 0; b.rw_a = 0; b.address_a = '0; b.data_in_a = '0;
        b.en_b = 0; b.rw_b = 0; b.address_b = '0; b.data_in_b = '0;
    endtask

    task automatic idle3();
        b3.en_a = 0; b3.rw_a = 0; b3.address_a = '0; b3.data_in_a = '0;
        b3.en_b = 0; b3.rw_b = 0; b3.address_b = '0; b3.data_in_b = '0;
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (b.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0h exp 0", b.ready); end
        checks++; if (b.data_out_a !== 7'h00 || b.data_out_b !== 7'h00) begin errors++;
            $display("FAIL reset_dout: got %0h/%0h exp 0/0", b.data_out_a, b.data_out_b); end
        checks++; if ({b.valid_a, b.valid_b, b.collision} !== 3'b000) begin errors++;
            $display("FAIL reset_strobes: got %b exp 000", {b.valid_a, b.valid_b, b.collision}); end
    endtask

    task automatic test_clear();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            b.en_a = (i == 5); b.rw_a = (i == 5);
            b.address_a = 5'd3; b.data_in_a = 7'h55;
            checks++; if (b.ready !== (i == 32)) begin errors++;
                $display("FAIL clear_ready cycle %0d: got %0h exp %0h", i, b.ready, (i == 32)); end
            checks++; if (b.valid_a !== 1'b0 || b.collision !== 1'b0) begin errors++;
                $display("FAIL clear_strobes cycle %0d: got %b exp 00", i, {b.valid_a, b.collision}); end
        end
        idle();
        b.en_a = 1; b.address_a = 5'd0; b.en_b = 1; b.address_b = 5'd17;
        step();
        checks++; if (b.data_out_a !== 7'h00 || b.valid_a !== 1'b1) begin errors++;
            $display("FAIL clear_rd0: got %0h v%0b exp 0 v1", b.data_out_a, b.valid_a); end
        checks++; if (b.data_out_b !== 7'h00 || b.valid_b !== 1'b1) begin errors++;
            $display("FAIL clear_rd17: got %0h v%0b exp 0 v1", b.data_out_b, b.valid_b); end
        b.address_a = 5'd31; b.address_b = 5'd3;
        step();
        checks++; if (b.data_out_a !== 7'h00 || b.valid_a !== 1'b1) begin errors++;
            $display("FAIL clear_rd31: got %0h v%0b exp 0 v1", b.data_out_a, b.valid_a); end
        checks++; if (b.data_out_b !== 7'h00 || b.valid_b !== 1'b1) begin errors++;
            $display("FAIL clear_ignored_wr3: got %0h v%0b exp 0 v1", b.data_out_b, b.valid_b); end
        idle();
        step();
        checks++; if (b.valid_a !== 1'b0 || b.valid_b !== 1'b0) begin errors++;
            $display("FAIL valid_one_cycle: got %b exp 00", {b.valid_a, b.valid_b}); end
    endtask

    task automatic test_independent();
        b.en_a = 1; b.rw_a = 1; b.address_a = 5'd4; b.data_in_a = 7'h12;
        b.en_b = 1; b.rw_b = 1; b.address_b = 5'd9; b.data_in_b = 7'h6A;
        step();
        checks++; if ({b.valid_a, b.valid_b, b.collision} !== 3'b000) begin errors++;
            $display("FAIL indep_wr_strobes: got %b exp 000", {b.valid_a, b.valid_b, b.collision}); end
        b.rw_a = 0; b.address_a = 5'd9; b.rw_b = 0; b.address_b = 5'd4;
        step();
        checks++; if (b.data_out_a !== 7'h6A || b.valid_a !== 1'b1) begin errors++;
            $display("FAIL indep_rd_a: got %0h v%0b exp 6a v1", b.data_out_a, b.valid_a); end
        checks++; if (b.data_out_b !== 7'h12 || b.valid_b !== 1'b1) begin errors++;
            $display("FAIL indep_rd_b: got %0h v%0b exp 12 v1", b.data_out_b, b.valid_b); end
        idle();
    endtask

    task automatic test_back_to_back();
        b.en_a = 1; b.address_a = 5'd4; b.en_b = 1; b.address_b = 5'd9;
        step();
        b.address_a = 5'd9; b.address_b = 5'd9;
        checks++; if (b.data_out_a !== 7'h12 || b.data_out_b !== 7'h6A || {b.valid_a, b.valid_b} !== 2'b11) begin errors++;
            $display("FAIL b2b_first: got %0h/%0h v%b exp 12/6a v11", b.data_out_a, b.data_out_b, {b.valid_a, b.valid_b}); end
        step();
        checks++; if (b.data_out_a !== 7'h6A || b.data_out_b !== 7'h6A || {b.valid_a, b.valid_b} !== 2'b11) begin errors++;
            $display("FAIL b2b_same_addr: got %0h/%0h v%b exp 6a/6a v11", b.data_out_a, b.data_out_b, {b.valid_a, b.valid_b}); end
        checks++; if (b.collision !== 1'b0) begin errors++; $display("FAIL b2b_no_coll: got %0b exp 0", b.collision); end
        idle();
        step();
    endtask

    task automatic test_collision();
        b.en_a = 1; b.rw_a = 1; b.address_a = 5'd10; b.data_in_a = 7'h01;
        b.en_b = 1; b.rw_b = 1; b.address_b = 5'd10; b.data_in_b = 7'h7F;
        step();
        checks++; if (b.collision !== 1'b1) begin errors++; $display("FAIL coll_set: got %0b exp 1", b.collision); end
        idle();
        b.en_b = 1; b.address_b = 5'd10;
        step();
        checks++; if (b.collision !== 1'b0) begin errors++; $display("FAIL coll_one_cycle: got %0b exp 0", b.collision); end
        checks++; if (b.data_out_b !== 7'h01) begin errors++; $display("FAIL coll_a_wins: got %0h exp 01", b.data_out_b); end
        idle();
    endtask

    task automatic test_read_before_write();
        b.en_a = 1; b.rw_a = 1; b.address_a = 5'd2; b.data_in_a = 7'h33;
        step();
        b.data_in_a = 7'h44;
        b.en_b = 1; b.rw_b = 0; b.address_b = 5'd2;
        step();
        checks++; if (b.data_out_b !== 7'h33 || b.valid_b !== 1'b1) begin errors++;
            $display("FAIL rbw_old: got %0h v%0b exp 33 v1", b.data_out_b, b.valid_b); end
        checks++; if (b.data_out_a !== 7'h6A || b.valid_a !== 1'b0) begin errors++;
            $display("FAIL wr_holds_dout: got %0h v%0b exp 6a v0", b.data_out_a, b.valid_a); end
        b.en_a = 0;
        step();
        checks++; if (b.data_out_b !== 7'h44) begin errors++; $display("FAIL rbw_new: got %0h exp 44", b.data_out_b); end
        idle();
    endtask

    task automatic test_reset_mid_op();
        b.en_a = 1; b.rw_a = 1; b.address_a = 5'd6; b.data_in_a = 7'h2B;
        step();
        idle();
        reset = 1'b1;
        #1;
        checks++; if (b.ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %0b exp 0", b.ready); end
        checks++; if (b.data_out_a !== 7'h00 || b.data_out_b !== 7'h00 || {b.valid_a, b.valid_b, b.collision} !== 3'b000) begin errors++;
            $display("FAIL midrst_outs: got %0h/%0h %b exp 0/0 000", b.data_out_a, b.data_out_b, {b.valid_a, b.valid_b, b.collision}); end
        step();
        reset = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            step();
            checks++; if (b.ready !== (i == 32)) begin errors++;
                $display("FAIL midrst_reclear cycle %0d: got %0b exp %0b", i, b.ready, (i == 32)); end
        end
        b.en_a = 1; b.address_a = 5'd6;
        step();
        checks++; if (b.data_out_a !== 7'h00 || b.valid_a !== 1'b1) begin errors++;
            $display("FAIL midrst_rd6: got %0h v%0b exp 0 v1", b.data_out_a, b.valid_a); end
        idle();
    endtask

    task automatic test_small_config();
        step();
        rst3 = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step();
            checks++; if (b3.ready !== (i == 8)) begin errors++;
                $display("FAIL small_ready cycle %0d: got %0b exp %0b", i, b3.ready, (i == 8)); end
        end
        for (int a = 0; a < 8; a++) begin
            b3.en_a = 1; b3.address_a = 3'(a);
            b3.en_b = 1; b3.address_b = 3'(7 - a);
            step();
            checks++; if (b3.data_out_a !== 12'hABC || b3.data_out_b !== 12'hABC || {b3.valid_a, b3.valid_b} !== 2'b11) begin errors++;
                $display("FAIL small_rd addr %0d: got %0h/%0h v%b exp abc/abc v11", a, b3.data_out_a, b3.data_out_b, {b3.valid_a, b3.valid_b}); end
        end
        idle3();
    endtask

    initial begin
        idle();
        idle3();
        test_reset();
        test_clear();
        test_independent();
        test_back_to_back();
        test_collision();
        test_read_before_write();
        test_reset_mid_op();
        test_small_config();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
